// File: rtl/fnd_pkg.sv
// Shared definitions for the FND humidity/temperature display blocks:
// digit-select codes, display limit, scan FSM states and the clamp helper.
package fnd_pkg;

  localparam logic [1:0] SEL_TE1  = 2'd0;
  localparam logic [1:0] SEL_TE10 = 2'd1;
  localparam logic [1:0] SEL_HU1  = 2'd2;
  localparam logic [1:0] SEL_HU10 = 2'd3;

  localparam logic [7:0] DISP_MAX = 8'd99;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  function automatic logic [7:0] disp_clamp(input logic [7:0] v);
    return (v > DISP_MAX) ? DISP_MAX : v;
  endfunction

endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and flags the terminal count as a
// one-cycle tick. Shared by the FND scan blocks.
module fnd_tick_gen #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fnd_humtemp_scan_ctrl.sv
// Scan controller for the 4-digit humidity/temperature FND: frame-aligned
// reading commit, digit select and blanked commons. FND_LZ_BLANK_EN hides leading zeros.
module fnd_humtemp_scan_ctrl #(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned SCAN_HZ   = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] humid_in,
  input  logic [7:0] temp_in,
  output logic [7:0] hu_out,
  output logic [7:0] te_out,
  output logic [1:0] sel,
  output logic [3:0] fnd_com,
  output logic       frame_done
);

  import fnd_pkg::*;

  localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  logic tick;

  fnd_tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  scan_state_t   state, state_nx;
  logic [BW-1:0] blank_cnt, blank_cnt_nx;

  logic [7:0] pend_hu, pend_te;
  logic [7:0] hu_nx, te_nx;
  logic [1:0] sel_nx;
  logic [3:0] fnd_com_nx;
  logic       xfer, commit, in_ready_nx;

  // in_ready doubles as the inverted pending-full flag.
  assign xfer   = in_valid && in_ready;
  assign commit = tick && (sel == SEL_HU10) && !in_ready;

  always_comb begin
    sel_nx      = tick ? sel + 2'd1 : sel;
    hu_nx       = commit ? pend_hu : hu_out;
    te_nx       = commit ? pend_te : te_out;
    in_ready_nx = in_ready;
    if (xfer) begin
      in_ready_nx = 1'b0;
    end else if (commit) begin
      in_ready_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_BLANK;
      blank_cnt <= '0;
    end else begin
      state     <= state_nx;
      blank_cnt <= blank_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    blank_cnt_nx = blank_cnt;
    if (tick) begin
      state_nx     = (BLANK_CYC == 0) ? S_SHOW : S_BLANK;
      blank_cnt_nx = '0;
    end else begin
      case (state)
        S_BLANK: begin
          if (BLANK_CYC == 0 || blank_cnt == BLANK_LAST) begin
            state_nx     = S_SHOW;
            blank_cnt_nx = '0;
          end else begin
            blank_cnt_nx = blank_cnt + BW'(1);
          end
        end
        S_SHOW:  state_nx = S_SHOW;
        default: state_nx = S_BLANK;
      endcase
    end
  end

  // Commons are decoded from the next state/select/values so the registered
  // fnd_com lines up with the registered sel and display values.
  always_comb begin
    fnd_com_nx = '1;
    if (state_nx == S_SHOW) begin
      fnd_com_nx = ~(4'b0001 << sel_nx);
`ifdef FND_LZ_BLANK_EN
      if ((sel_nx == SEL_TE10 && te_nx < 8'd10) ||
          (sel_nx == SEL_HU10 && hu_nx < 8'd10)) begin
        fnd_com_nx = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= SEL_TE1;
      fnd_com    <= '1;
      frame_done <= 1'b0;
      in_ready   <= 1'b1;
      pend_hu    <= '0;
      pend_te    <= '0;
      hu_out     <= '0;
      te_out     <= '0;
    end else begin
      sel        <= sel_nx;
      fnd_com    <= fnd_com_nx;
      frame_done <= tick && (sel == SEL_HU10);
      in_ready   <= in_ready_nx;
      hu_out     <= hu_nx;
      te_out     <= te_nx;
      if (xfer) begin
        pend_hu <= disp_clamp(humid_in);
        pend_te <= disp_clamp(temp_in);
      end
    end
  end

endmodule

// File: tb/tb_fnd_humtemp_scan_ctrl.sv
// Bench for fnd_humtemp_scan_ctrl at TICK_DIV=8, BLANK_CYC=2: reset-frame
// vector table, reading table with commit scoreboard, and corner sequences.
module tb_fnd_humtemp_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] humid_in = '0;
  logic [7:0] temp_in = '0;
  logic [7:0] hu_out, te_out;
  logic [1:0] sel;
  logic [3:0] fnd_com;
  logic       frame_done;

  fnd_humtemp_scan_ctrl #(
    .CLK_HZ   (8000),
    .SCAN_HZ  (1000),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .humid_in  (humid_in),
    .temp_in   (temp_in),
    .hu_out    (hu_out),
    .te_out    (te_out),
    .sel       (sel),
    .fnd_com   (fnd_com),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

`ifdef FND_LZ_BLANK_EN
  localparam bit LZ_ON = 1'b1;
`else
  localparam bit LZ_ON = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] sel;
    logic [3:0] com;
    logic       fd;
  } vec_t;

  typedef struct {
    logic [7:0] humid;
    logic [7:0] temp;
    logic [7:0] exp_hu;
    logic [7:0] exp_te;
  } rd_t;

  typedef struct {
    logic [7:0] hu;
    logic [7:0] te;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] lz_adj(input logic [1:0] s, input logic [3:0] com,
                                        input logic [7:0] hu, input logic [7:0] te);
    if (LZ_ON && ((s == 2'd1 && te < 8'd10) || (s == 2'd3 && hu < 8'd10))) return 4'b1111;
    return com;
  endfunction

  task automatic wait_frame(output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n = i + 1;
      if (frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL frame_timeout @cyc %0d: got no frame_done expected pulse within 40", cyc);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb_empty: got commit expected queued reading", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_hu"}, 32'(hu_out), 32'(e.hu));
      check({tag, "_te"}, 32'(te_out), 32'(e.te));
    end
  endtask

  vec_t       tbl[13];
  rd_t        rds[4];
  logic [3:0] ec;
  int         n;

  initial begin
    tbl[0]  = '{0,  2'd0, 4'b1111, 1'b0};
    tbl[1]  = '{1,  2'd0, 4'b1111, 1'b0};
    tbl[2]  = '{2,  2'd0, 4'b1110, 1'b0};
    tbl[3]  = '{7,  2'd0, 4'b1110, 1'b0};
    tbl[4]  = '{8,  2'd1, 4'b1111, 1'b0};
    tbl[5]  = '{9,  2'd1, 4'b1111, 1'b0};
    tbl[6]  = '{10, 2'd1, 4'b1101, 1'b0};
    tbl[7]  = '{16, 2'd2, 4'b1111, 1'b0};
    tbl[8]  = '{18, 2'd2, 4'b1011, 1'b0};
    tbl[9]  = '{24, 2'd3, 4'b1111, 1'b0};
    tbl[10] = '{26, 2'd3, 4'b0111, 1'b0};
    tbl[11] = '{31, 2'd3, 4'b0111, 1'b0};
    tbl[12] = '{32, 2'd0, 4'b1111, 1'b1};

    rds[0] = '{8'd45,  8'd23,  8'd45, 8'd23};
    rds[1] = '{8'd150, 8'd255, 8'd99, 8'd99};
    rds[2] = '{8'd99,  8'd100, 8'd99, 8'd99};
    rds[3] = '{8'd5,   8'd7,   8'd5,  8'd7};

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_hu", 32'(hu_out), 32'd0);
    check("rst_te", 32'(te_out), 32'd0);
    rst_n = 1'b1;
    cyc   = 0;

    // First frame after reset, hu_out/te_out still 0.
    for (int i = 0; i < 13; i++) begin
      while (cyc < tbl[i].cyc) step();
      check($sformatf("f0_sel_c%0d", tbl[i].cyc), 32'(sel), 32'(tbl[i].sel));
      check($sformatf("f0_com_c%0d", tbl[i].cyc), 32'(fnd_com),
            32'(lz_adj(tbl[i].sel, tbl[i].com, 8'd0, 8'd0)));
      check($sformatf("f0_fd_c%0d", tbl[i].cyc), 32'(frame_done), 32'(tbl[i].fd));
    end

    // Readings: accept mid-frame, commit at the next frame boundary.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] prev_hu;
      prev_hu = hu_out;
      repeat (3) step();
      check("ready_before", 32'(in_ready), 32'd1);
      humid_in = rds[i].humid;
      temp_in  = rds[i].temp;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      sb.push_back('{rds[i].exp_hu, rds[i].exp_te});
      check("ready_drop", 32'(in_ready), 32'd0);
      if (i == 0) begin
        humid_in = 8'd60;
        temp_in  = 8'd60;
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("ignored_ready", 32'(in_ready), 32'd0);
      end
      check("hold_before_frame", 32'(hu_out), 32'(prev_hu));
      wait_frame(n);
      pop_check($sformatf("commit%0d", i));
      check("ready_rise", 32'(in_ready), 32'd1);
      check("sel_wrap", 32'(sel), 32'd0);
    end

    // Full frame with hu=5, te=7: tens digits lit only without leading-zero blanking.
    for (int k = 0; k < 32; k++) begin
      ec = ((k % 8) < 2) ? 4'b1111 : ~(4'b0001 << (k / 8));
      ec = lz_adj(2'(k / 8), ec, 8'd5, 8'd7);
      check($sformatf("lz_com_k%0d", k), 32'(fnd_com), 32'(ec));
      step();
    end

    // in_valid held across a commit: no transfer in the commit cycle, taken right after.
    repeat (3) step();
    humid_in = 8'd12;
    temp_in  = 8'd34;
    in_valid = 1'b1;
    step();
    sb.push_back('{8'd12, 8'd34});
    humid_in = 8'd56;
    temp_in  = 8'd78;
    wait_frame(n);
    pop_check("simul_a");
    check("ready_at_commit", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    sb.push_back('{8'd56, 8'd78});
    check("simul_accept", 32'(in_ready), 32'd0);
    wait_frame(n);
    pop_check("simul_b");

    // Reset mid-frame with a reading pending: discarded, no later commit.
    repeat (3) step();
    humid_in = 8'd90;
    temp_in  = 8'd80;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && sel != 2'd2; i++) step();
    check("pre_rst_sel", 32'(sel), 32'd2);
    check("pre_rst_ready", 32'(in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_com", 32'(fnd_com), 32'hF);
    check("arst_sel", 32'(sel), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_hu", 32'(hu_out), 32'd0);
    check("arst_te", 32'(te_out), 32'd0);
    check("arst_fd", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    wait_frame(n);
    check("post_rst_frame_len", 32'(n), 32'd32);
    check("post_rst_hu", 32'(hu_out), 32'd0);
    check("post_rst_te", 32'(te_out), 32'd0);
    check("post_rst_ready", 32'(in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
